// File: rtl/clock_controller.sv
// CPU clock front-end: debounced panel buttons feed a STOPPED/RUNNING/HALTED
// sequencer that issues a one-cycle datapath enable and a panel-rate clock level.
module clock_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DIV0            = 25000000,
  parameter int DIV1            = 2500000,
  parameter int DIV2            = 250000,
  parameter int DIV3            = 2500
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic       btn_start_stop_i,
  input  logic       btn_step_i,
  input  logic       btn_speed_i,
  input  logic       halt_i,
  output logic       cpu_ce,
  output logic       cpu_clk,
  output logic       running,
  output logic       halted,
  output logic [1:0] speed_idx
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int BTN_SS    = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_SPEED = 2;

  logic [2:0] btn_raw;
  logic [2:0] press_w;
  logic       step_level;

  assign btn_raw = {btn_speed_i, btn_step_i, btn_start_stop_i};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync0_reg;
      logic             sync1_reg;
      logic             deb_reg;
      logic             deb_prev_reg;
      logic             press_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      always_ff @(posedge clk_i) begin
        if (rst) begin
          sync0_reg    <= 1'b0;
          sync1_reg    <= 1'b0;
          deb_reg      <= 1'b0;
          deb_prev_reg <= 1'b0;
          press_reg    <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync0_reg    <= btn_raw[gi];
          sync1_reg    <= sync0_reg;
          deb_prev_reg <= deb_reg;
          press_reg    <= deb_reg & ~deb_prev_reg;
          if (sync1_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg >= CNT_LAST) begin
            deb_reg <= sync1_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press_w[gi] = press_reg;

      if (gi == BTN_STEP) begin : g_lvl
        assign step_level = deb_reg;
      end
    end
  endgenerate

  logic press_ss;
  logic press_step;
  logic press_speed;

  assign press_ss    = press_w[BTN_SS];
  assign press_step  = press_w[BTN_STEP];
  assign press_speed = press_w[BTN_SPEED];

  function automatic logic [31:0] div_of(input logic [1:0] idx);
    case (idx)
      2'd0:    div_of = 32'(DIV0);
      2'd1:    div_of = 32'(DIV1);
      2'd2:    div_of = 32'(DIV2);
      default: div_of = 32'(DIV3);
    endcase
  endfunction

  typedef enum logic [1:0] {ST_STOPPED, ST_RUNNING, ST_HALTED} state_t;

  state_t      state_reg;
  logic [31:0] count_reg;
  logic [1:0]  speed_reg;
  logic        ce_reg;
  logic        clk_reg;
  logic        running_reg;
  logic        halted_reg;

  logic [1:0]  speed_next;
  logic [31:0] div_cur;
  logic [31:0] div_new;
  logic [31:0] count_run;

  // A speed change restarts the period so the new divider never sees a stale count.
  always_comb begin
    speed_next = press_speed ? speed_reg + 2'd1 : speed_reg;
    div_cur    = div_of(speed_reg);
    div_new    = div_of(speed_next);
    if (press_speed || count_reg >= div_cur - 32'd1) begin
      count_run = '0;
    end else begin
      count_run = count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_reg   <= ST_STOPPED;
      count_reg   <= '0;
      speed_reg   <= 2'd0;
      ce_reg      <= 1'b0;
      clk_reg     <= 1'b0;
      running_reg <= 1'b0;
      halted_reg  <= 1'b0;
    end else begin
      speed_reg <= speed_next;
      ce_reg    <= 1'b0;
      case (state_reg)
        ST_STOPPED: begin
          count_reg <= '0;
          clk_reg   <= step_level;
          if (halt_i) begin
            state_reg  <= ST_HALTED;
            halted_reg <= 1'b1;
            clk_reg    <= 1'b0;
          end else if (press_ss) begin
            state_reg   <= ST_RUNNING;
            running_reg <= 1'b1;
            clk_reg     <= 1'b1;
          end else if (press_step) begin
            ce_reg <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (halt_i) begin
            state_reg   <= ST_HALTED;
            running_reg <= 1'b0;
            halted_reg  <= 1'b1;
            count_reg   <= '0;
            clk_reg     <= 1'b0;
          end else if (press_ss) begin
            state_reg   <= ST_STOPPED;
            running_reg <= 1'b0;
            count_reg   <= '0;
            clk_reg     <= step_level;
          end else begin
            count_reg <= count_run;
            ce_reg    <= (count_run == div_new - 32'd1);
            clk_reg   <= (count_run < (div_new >> 1));
          end
        end
        default: begin
          count_reg <= '0;
          clk_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Halt must kill an enable already sitting in the output register this cycle.
  assign cpu_ce    = ce_reg & ~halt_i;
  assign cpu_clk   = clk_reg;
  assign running   = running_reg;
  assign halted    = halted_reg;
  assign speed_idx = speed_reg;

endmodule

// File: tb/tb_clock_controller.sv
// Directed-sequence bench with randomized timing; expected cpu_ce cycles come
// from period arithmetic over run segments, not from the sequencer's registers.
module tb_clock_controller;

  localparam int D = 4;

  logic       clk_i = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start_stop_i = 1'b0;
  logic       btn_step_i = 1'b0;
  logic       btn_speed_i = 1'b0;
  logic       halt_i = 1'b0;
  logic       cpu_ce;
  logic       cpu_clk;
  logic       running;
  logic       halted;
  logic [1:0] speed_idx;

  clock_controller #(
    .DEBOUNCE_CYCLES(D),
    .DIV0(8),
    .DIV1(6),
    .DIV2(4),
    .DIV3(2)
  ) dut (
    .clk_i(clk_i),
    .rst(rst),
    .btn_start_stop_i(btn_start_stop_i),
    .btn_step_i(btn_step_i),
    .btn_speed_i(btn_speed_i),
    .halt_i(halt_i),
    .cpu_ce(cpu_ce),
    .cpu_clk(cpu_clk),
    .running(running),
    .halted(halted),
    .speed_idx(speed_idx)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int got_q[$];
  int exp_q[$];
  always @(negedge clk_i) if (cpu_ce === 1'b1) got_q.push_back(cyc);

  int n_pass = 0;
  int n_total = 0;

  function automatic int div_of(input int i);
    case (i)
      0:       return 8;
      1:       return 6;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic at(input int t);
    goto(t);
    @(negedge clk_i);
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0:       btn_start_stop_i = v;
      1:       btn_step_i = v;
      default: btn_speed_i = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    int c;
    c = cyc;
    drive(which, 1'b1);
    goto(c + hold);
    drive(which, 1'b0);
  endtask

  // Running from count 0 at cycle s with period d until cycle e (exclusive).
  task automatic add_segment(input int s, input int d, input int e);
    for (int t = s + d - 1; t < e; t += d) exp_q.push_back(t);
  endtask

  task automatic compare_log(input string tag);
    chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_ce[%0d]", tag, i), got_q[i], exp_q[i]);
    $display("%s: %0d cpu_ce pulses logged, %0d expected", tag, got_q.size(), exp_q.size());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c, c1, g, h, t0, r, seg_s, seg_d, idx_m, cs, cq, cb, k, th, ca, cm;

    // Reset values
    at(2);
    chk("rst_cpu_ce", cpu_ce, 0);
    chk("rst_cpu_clk", cpu_clk, 0);
    chk("rst_running", running, 0);
    chk("rst_halted", halted, 0);
    chk("rst_speed_idx", speed_idx, 0);
    goto(3);
    rst = 1'b0;

    // Short step glitch, then a clean step press
    goto(5);
    c = cyc;
    g = $urandom_range(1, D - 1);
    press(1, g);
    goto(c + g + 10 + $urandom_range(0, 5));
    c1 = cyc;
    h = $urandom_range(12, 20);
    btn_step_i = 1'b1;
    at(c1 + 7);
    chk("step_ce_early", cpu_ce, 0);
    at(c1 + 8);
    chk("step_ce", cpu_ce, 1);
    at(c1 + 10);
    chk("step_cpu_clk_held", cpu_clk, 1);
    goto(c1 + h);
    btn_step_i = 1'b0;
    at(c1 + h + 14);
    chk("step_running", running, 0);
    chk("step_cpu_clk_released", cpu_clk, 0);
    exp_q.push_back(c1 + 8);
    compare_log("step");

    // Start running; check first period and cpu_clk duty
    goto(cyc + $urandom_range(3, 8));
    c = cyc;
    press(0, $urandom_range(5, 7));
    at(c + 7);
    chk("start_running_early", running, 0);
    t0 = c + 8;
    for (int i = 0; i < 8; i++) begin
      at(t0 + i);
      if (i == 0) begin
        chk("start_running", running, 1);
        chk("start_halted", halted, 0);
      end
      chk($sformatf("duty_cpu_clk[%0d]", i), cpu_clk, (i < 4) ? 1 : 0);
    end

    // Four speed presses while running, each restarting the period
    seg_s = t0;
    seg_d = 8;
    idx_m = 0;
    r = $urandom_range(1, 3);
    goto(t0 + r * 8 + $urandom_range(0, 7));
    for (int n = 0; n < 4; n++) begin
      cs = cyc;
      press(2, $urandom_range(5, 7));
      idx_m = (idx_m + 1) % 4;
      add_segment(seg_s, seg_d, cs + 8);
      at(cs + 8);
      chk($sformatf("speed_idx[%0d]", n), speed_idx, idx_m);
      seg_s = cs + 8;
      seg_d = div_of(idx_m);
      goto(cs + 20 + $urandom_range(0, 10));
    end

    // Stop
    goto(cyc + $urandom_range(5, 20));
    cq = cyc;
    press(0, $urandom_range(5, 7));
    add_segment(seg_s, seg_d, cq + 8);
    at(cq + 8);
    chk("stop_running", running, 0);
    chk("stop_cpu_clk", cpu_clk, 0);
    at(cq + 20);
    compare_log("run");

    // Start/stop and step together while stopped: run, no step pulse
    goto(cq + 22);
    cb = cyc;
    btn_start_stop_i = 1'b1;
    btn_step_i = 1'b1;
    goto(cb + 6);
    btn_start_stop_i = 1'b0;
    btn_step_i = 1'b0;
    at(cb + 8);
    chk("both_running", running, 1);
    seg_s = cb + 8;

    // Halt in a cycle where count == 7
    k = $urandom_range(1, 3);
    th = seg_s + 8 * k - 1;
    goto(th);
    halt_i = 1'b1;
    at(th);
    chk("halt_ce_suppressed", cpu_ce, 0);
    chk("halt_not_yet", halted, 0);
    add_segment(seg_s, 8, th);
    goto(th + 1);
    halt_i = 1'b0;
    at(th + 1);
    chk("halt_halted", halted, 1);
    chk("halt_running", running, 0);
    chk("halt_cpu_clk", cpu_clk, 0);

    // Presses while halted: start/stop and step ignored, speed still applies
    ca = th + 5;
    goto(ca);
    press(0, 6);
    goto(ca + 10);
    press(1, 6);
    goto(ca + 20);
    press(2, 6);
    at(ca + 28);
    chk("halted_speed_idx", speed_idx, 1);
    chk("halted_still", halted, 1);
    chk("halted_running", running, 0);
    at(ca + 40);
    compare_log("halt");

    // Reset out of HALTED
    goto(ca + 41);
    rst = 1'b1;
    goto(ca + 42);
    rst = 1'b0;
    at(ca + 42);
    chk("rst2_halted", halted, 0);
    chk("rst2_running", running, 0);
    chk("rst2_speed_idx", speed_idx, 0);
    chk("rst2_cpu_ce", cpu_ce, 0);
    chk("rst2_cpu_clk", cpu_clk, 0);

    // Reset mid-debounce of a start/stop press
    cm = ca + 45;
    goto(cm);
    btn_start_stop_i = 1'b1;
    r = $urandom_range(1, 3);
    goto(cm + r);
    rst = 1'b1;
    goto(cm + r + 1);
    rst = 1'b0;
    goto(cm + 5);
    btn_start_stop_i = 1'b0;
    at(cm + 12);
    chk("midrst_running", running, 0);
    at(cm + 30);
    chk("midrst_running_late", running, 0);
    compare_log("midrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
